mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store stage directly downstream of the ALU: takes the ALU's effective address (`Addr`) and the store operand (`busB`) and runs one data-memory transaction over a req/ack bus. It handles byte/halfword/word alignment, byte enables and sign/zero extension, and stalls the pipeline until the access completes. The load result goes to writeback.

## Interface
- `TIMEOUT`, default 255: cycles `mem_req` may wait for `mem_ack` before aborting (1..255).
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  memory instruction valid; sampled only in IDLE.
- `mem_op`  in  3  000 LB, 001 LH, 010 LW, 011 SB, 100 LBU, 101 LHU, 110 SH, 111 SW.
- `Addr`  in  32  effective address from ALU.
- `busB`  in  32  store data.
- `stall`  out  1  freeze pipeline.
- `done`  out  1  one-cycle completion pulse.
- `rd_data`  out  32  extended load result; valid with `done`, held until next `done`.
- `misalign`  out  1  one-cycle pulse: access rejected for alignment.
- `bus_err`  out  1  one-cycle pulse: ack timeout.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  word address, `{Addr[31:2],2'b00}`.
- `mem_be`  out  4  byte enables, bit n = byte lane n (little-endian).
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_rdata`  in  32  read data, valid when `mem_ack`=1.
- `mem_ack`  in  1  transaction complete.

## Operation
- States: IDLE, REQ, DONE, FAULT.
- IDLE + `start`: latch `mem_op`, `Addr`, `busB`. Misaligned → FAULT, else → REQ. `start` in other states is ignored.
- Misaligned: LH/LHU/SH with `Addr[0]`=1; LW/SW with `Addr[1:0]`≠0. No bus request is issued.
- REQ: `mem_req`=1 and all `mem_*` outputs held stable. When `mem_ack` is sampled high: for a load, capture the extracted value into `rd_data`; → DONE.
- Timeout: an 8-bit counter clears on entry to REQ and increments each REQ cycle without ack. If no ack arrives by count `TIMEOUT`-1, → FAULT with `bus_err`. An ack in that same cycle wins (normal completion).
- DONE: `done`=1 for one cycle → IDLE.
- FAULT: `done`=1 plus `misalign` or `bus_err`=1 for one cycle. `rd_data` is unchanged. → IDLE.
- Byte enables and write data:
  - SB: `mem_be` = 1<<`Addr[1:0]`, `mem_wdata` = {4{`busB[7:0]`}}.
  - SH: `mem_be` = `Addr[1]` ? 1100 : 0011, `mem_wdata` = {2{`busB[15:0]`}}.
  - SW: `mem_be` = 1111, `mem_wdata` = `busB`.
  - Loads use the same `mem_be` rules with `mem_we`=0.
- Load extract: the lane is `mem_rdata >> (8*Addr[1:0])`, truncated to 8/16 bits. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through unchanged.
- `stall` = (IDLE & `start`) | REQ | FAULT-entry pending. Concretely, `stall` is high from the `start` cycle through the last REQ cycle and low in DONE/FAULT, so the pipeline advances in the `done` cycle.

## Timing
- Reset: state IDLE. `stall`, `done`, `misalign`, `bus_err`, `mem_req`, `mem_we` = 0; `mem_addr`, `mem_be`, `mem_wdata`, `rd_data`, counter = 0.
- Reset during REQ drops `mem_req` immediately (asynchronous); no `done` is produced.
- Minimum latency: `start` at cycle 0, `mem_req` first high at cycle 1, ack at cycle 1, `done` at cycle 2.
- General latency: `done` = 1 + (cycles waiting for ack, ≥1) + 1.
- Misalign: `start` at cycle 0, `done`/`misalign` at cycle 1; `mem_req` never asserts.
- Timeout: `bus_err` at cycle `TIMEOUT`+1 after `start`; `mem_req` deasserts that same cycle.
- `mem_req` deasserts in the cycle after ack is sampled. Back-to-back: the next `start` is accepted in the IDLE cycle after `done`.

## Test plan
- LW, `Addr`=0x100, ack after 3 cycles, `mem_rdata`=0xDEADBEEF → `mem_be`=1111, `mem_we`=0, `rd_data`=0xDEADBEEF, `done` at cycle 5, `stall` high cycles 0–4.
- LB / LBU, `Addr`=0x103, `mem_rdata`=0x80112233 → `mem_be`=1000; `rd_data`=0xFFFFFF80 for LB, 0x00000080 for LBU.
- SH, `Addr`=0x22, `busB`=0x1234ABCD → `mem_addr`=0x20, `mem_be`=1100, `mem_wdata`=0xABCDABCD, `mem_we`=1; ack immediate → `done` at cycle 2.
- LW, `Addr`=0x102 → `misalign`+`done` at cycle 1, no `mem_req`, `rd_data` unchanged.
- SW, no ack, `TIMEOUT`=4 → `bus_err`+`done` at cycle 5, `mem_req` low afterwards; repeat with ack exactly at the final count → normal `done`, no `bus_err`.
- `rst` asserted mid-REQ → all outputs 0 immediately; a following LW completes normally.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge bus between the load/store stage and the
// data memory.
//   mem_req   : transaction request, held until acknowledged
//   mem_we    : 1 = write, 0 = read
//   mem_addr  : word-aligned address
//   mem_be    : byte enables, bit n = byte lane n (little-endian)
//   mem_wdata : lane-replicated store data
//   mem_rdata : read data, valid while mem_ack = 1
//   mem_ack   : transaction complete
// master = load/store unit side, slave = memory side.
interface mem_access_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store stage: runs one data-memory transaction per accepted memory
// instruction. Handles alignment checks, byte enables, store-lane replication,
// load sign/zero extension, an ack timeout, and pipeline stalling.
// Ports:
//   clk, rst  : clock (rising edge), asynchronous active-high reset
//   start     : memory instruction valid (sampled only when idle)
//   mem_op    : 000 LB, 001 LH, 010 LW, 011 SB, 100 LBU, 101 LHU, 110 SH, 111 SW
//   Addr      : effective address from the ALU
//   busB      : store data
//   stall     : freeze pipeline
//   done      : one-cycle completion pulse (normal or faulted)
//   rd_data   : extended load result, valid with done, held until next load
//   misalign  : one-cycle pulse, access rejected for alignment
//   bus_err   : one-cycle pulse, ack timeout
//   bus       : data-memory bus (master side)
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  mem_op,
    input  logic [31:0] Addr,
    input  logic [31:0] busB,
    output logic        stall,
    output logic        done,
    output logic [31:0] rd_data,
    output logic        misalign,
    output logic        bus_err,
    mem_access_unit_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    // ---------------------------------------------------------------------
    // Opcode decode helpers
    // ---------------------------------------------------------------------
    function automatic logic op_is_load(input logic [2:0] op);
        case (op)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: op_is_load = 1'b1;
            default:                                op_is_load = 1'b0;
        endcase
    endfunction

    // 0 = byte, 1 = halfword, 2 = word
    function automatic logic [1:0] op_size(input logic [2:0] op);
        case (op)
            3'b000, 3'b011, 3'b100: op_size = 2'd0;
            3'b001, 3'b101, 3'b110: op_size = 2'd1;
            default:                op_size = 2'd2;
        endcase
    endfunction

    function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] lo);
        case (op_size(op))
            2'd0:    op_misaligned = 1'b0;
            2'd1:    op_misaligned = lo[0];
            default: op_misaligned = (lo != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] op_be(input logic [2:0] op, input logic [1:0] lo);
        case (op_size(op))
            2'd0:    op_be = 4'b0001 << lo;
            2'd1:    op_be = lo[1] ? 4'b1100 : 4'b0011;
            default: op_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] op_wdata(input logic [2:0] op, input logic [31:0] data);
        case (op_size(op))
            2'd0:    op_wdata = {4{data[7:0]}};
            2'd1:    op_wdata = {2{data[15:0]}};
            default: op_wdata = data;
        endcase
    endfunction

    // Shift the addressed lane down to bit 0, then extend to 32 bits.
    function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] lo,
                                                 input logic [31:0] rdata);
        logic [31:0] lane;
        lane = rdata >> {lo, 3'b000};
        case (op)
            3'b000:  load_extract = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_extract = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_extract = {24'h000000, lane[7:0]};
            3'b101:  load_extract = {16'h0000, lane[15:0]};
            default: load_extract = rdata;
        endcase
    endfunction

    // ---------------------------------------------------------------------
    // State and registers
    // ---------------------------------------------------------------------
    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_op;
    logic [1:0]  r_addr_lo;
    logic [7:0]  r_cnt;
    logic        r_done;
    logic        r_misalign;
    logic        r_bus_err;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_rd_data;

    logic        w_accept;
    logic        w_start_misaligned;
    logic        w_take_misalign;
    logic        w_take_timeout;
    logic        w_ack_in_req;
    logic        w_stall;

    // Next-state decode, fault classification and stall.
    always_comb begin
        w_next             = r_state;
        w_accept           = 1'b0;
        w_start_misaligned = op_misaligned(mem_op, Addr[1:0]);
        w_take_misalign    = 1'b0;
        w_take_timeout     = 1'b0;
        w_ack_in_req       = 1'b0;
        w_stall            = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_stall  = 1'b1;
                    if (w_start_misaligned) begin
                        w_next          = ST_FAULT;
                        w_take_misalign = 1'b1;
                    end else begin
                        w_next = ST_REQ;
                    end
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_REQ: begin
                w_stall = 1'b1;
                // An ack on the final count still completes normally.
                if (bus.mem_ack) begin
                    w_next       = ST_DONE;
                    w_ack_in_req = 1'b1;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_next         = ST_FAULT;
                    w_take_timeout = 1'b1;
                end else begin
                    w_next = ST_REQ;
                end
            end
            ST_DONE:  w_next = ST_IDLE;
            ST_FAULT: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // State register, registered bus/status outputs, timeout counter, load capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_op        <= 3'b000;
            r_addr_lo   <= 2'b00;
            r_cnt       <= 8'd0;
            r_done      <= 1'b0;
            r_misalign  <= 1'b0;
            r_bus_err   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'h0000_0000;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= 32'h0000_0000;
            r_rd_data   <= 32'h0000_0000;
        end else begin
            r_state    <= w_next;
            r_done     <= (w_next == ST_DONE) || (w_next == ST_FAULT);
            r_misalign <= w_take_misalign;
            r_bus_err  <= w_take_timeout;
            r_mem_req  <= (w_next == ST_REQ);

            if (w_accept) begin
                r_op      <= mem_op;
                r_addr_lo <= Addr[1:0];
                // Bus fields only change for an access that will go out, so they
                // stay stable for the whole request.
                if (!w_start_misaligned) begin
                    r_mem_we    <= !op_is_load(mem_op);
                    r_mem_addr  <= {Addr[31:2], 2'b00};
                    r_mem_be    <= op_be(mem_op, Addr[1:0]);
                    r_mem_wdata <= op_wdata(mem_op, busB);
                end else begin
                    r_mem_we <= r_mem_we;
                end
            end else begin
                r_op <= r_op;
            end

            if (w_accept) begin
                r_cnt <= 8'd0;
            end else if ((r_state == ST_REQ) && !bus.mem_ack) begin
                r_cnt <= r_cnt + 8'd1;
            end else begin
                r_cnt <= r_cnt;
            end

            if (w_ack_in_req && op_is_load(r_op)) begin
                r_rd_data <= load_extract(r_op, r_addr_lo, bus.mem_rdata);
            end else begin
                r_rd_data <= r_rd_data;
            end
        end
    end

    // stall must rise in the start cycle itself, so it is decoded from state + start.
    assign stall         = w_stall;
    assign done          = r_done;
    assign misalign      = r_misalign;
    assign bus_err       = r_bus_err;
    assign rd_data       = r_rd_data;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT = 4).
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  mem_op;
    logic [31:0] Addr;
    logic [31:0] busB;
    logic        stall;
    logic        done;
    logic [31:0] rd_data;
    logic        misalign;
    logic        bus_err;

    mem_access_unit_if bus_if ();

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mem_op   (mem_op),
        .Addr     (Addr),
        .busB     (busB),
        .stall    (stall),
        .done     (done),
        .rd_data  (rd_data),
        .misalign (misalign),
        .bus_err  (bus_err),
        .bus      (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    // Observations of the last access.
    int          obs_done_cyc;
    logic        obs_req_seen;
    logic        obs_misalign;
    logic        obs_bus_err;
    logic        obs_req_at_done;
    logic        obs_we;
    logic [31:0] obs_addr;
    logic [3:0]  obs_be;
    logic [31:0] obs_wdata;
    logic [31:0] obs_rd;
    logic [19:0] obs_stall;

    // Drive one instruction starting in the next cycle (cycle 0). The memory
    // acks after wait_n request cycles without ack (255 = never). Ends sampled
    // in the done cycle, or after 20 cycles with obs_done_cyc = -1.
    task automatic do_access(input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input int wait_n,
                             input logic [31:0] rdata);
        int req_cnt;
        req_cnt         = 0;
        obs_done_cyc    = -1;
        obs_req_seen    = 1'b0;
        obs_misalign    = 1'b0;
        obs_bus_err     = 1'b0;
        obs_req_at_done = 1'b0;
        obs_we          = 1'b0;
        obs_addr        = 32'h0;
        obs_be          = 4'h0;
        obs_wdata       = 32'h0;
        obs_rd          = 32'h0;
        obs_stall       = 20'h0;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            start             = (cyc == 0);
            mem_op            = op;
            Addr              = a;
            busB              = b;
            bus_if.mem_rdata  = rdata;
            bus_if.mem_ack    = bus_if.mem_req && (req_cnt == wait_n);
            #1;
            obs_stall[cyc] = stall;
            if (bus_if.mem_req) begin
                if (!obs_req_seen) begin
                    obs_we    = bus_if.mem_we;
                    obs_addr  = bus_if.mem_addr;
                    obs_be    = bus_if.mem_be;
                    obs_wdata = bus_if.mem_wdata;
                end
                obs_req_seen = 1'b1;
                req_cnt++;
            end
            if (done) begin
                obs_done_cyc    = cyc;
                obs_misalign    = misalign;
                obs_bus_err     = bus_err;
                obs_req_at_done = bus_if.mem_req;
                obs_rd          = rd_data;
                bus_if.mem_ack  = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        start          = 1'b0;
        bus_if.mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({stall, done, misalign, bus_err, bus_if.mem_req, bus_if.mem_we} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {stall, done, misalign, bus_err, bus_if.mem_req, bus_if.mem_we});
        end
        tests++;
        if ({bus_if.mem_addr, bus_if.mem_be, bus_if.mem_wdata, rd_data} !== 100'h0) begin
            fails++;
            $display("FAIL reset_data: addr %h be %b wdata %h rd %h want all 0",
                     bus_if.mem_addr, bus_if.mem_be, bus_if.mem_wdata, rd_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_lw();
        do_access(3'b010, 32'h0000_0100, 32'h0, 3, 32'hDEAD_BEEF);
        tests++;
        if (obs_done_cyc != 5) begin
            fails++; $display("FAIL lw_latency: got %0d want 5", obs_done_cyc);
        end
        tests++;
        if ({obs_we, obs_be, obs_addr} !== {1'b0, 4'b1111, 32'h0000_0100}) begin
            fails++; $display("FAIL lw_bus: we %b be %b addr %h want 0 1111 00000100",
                              obs_we, obs_be, obs_addr);
        end
        tests++;
        if (obs_rd !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL lw_data: got %h want deadbeef", obs_rd);
        end
        tests++;
        if (obs_stall[5:0] !== 6'b011111) begin
            fails++; $display("FAIL lw_stall: got %b want 011111", obs_stall[5:0]);
        end
    endtask

    task automatic test_byte_loads();
        do_access(3'b000, 32'h0000_0103, 32'h0, 0, 32'h8011_2233);
        tests++;
        if ({obs_done_cyc == 2, obs_be, obs_rd} !== {1'b1, 4'b1000, 32'hFFFF_FF80}) begin
            fails++; $display("FAIL lb: cyc %0d be %b rd %h want 2 1000 ffffff80",
                              obs_done_cyc, obs_be, obs_rd);
        end
        do_access(3'b100, 32'h0000_0103, 32'h0, 0, 32'h8011_2233);
        tests++;
        if ({obs_be, obs_rd} !== {4'b1000, 32'h0000_0080}) begin
            fails++; $display("FAIL lbu: be %b rd %h want 1000 00000080", obs_be, obs_rd);
        end
    endtask

    task automatic test_half_loads();
        do_access(3'b001, 32'h0000_0202, 32'h0, 1, 32'h8001_7FFF);
        tests++;
        if ({obs_done_cyc == 3, obs_be, obs_rd} !== {1'b1, 4'b1100, 32'hFFFF_8001}) begin
            fails++; $display("FAIL lh: cyc %0d be %b rd %h want 3 1100 ffff8001",
                              obs_done_cyc, obs_be, obs_rd);
        end
        do_access(3'b101, 32'h0000_0200, 32'h0, 0, 32'h8001_F00D);
        tests++;
        if ({obs_be, obs_rd} !== {4'b0011, 32'h0000_F00D}) begin
            fails++; $display("FAIL lhu: be %b rd %h want 0011 0000f00d", obs_be, obs_rd);
        end
    endtask

    task automatic test_stores();
        do_access(3'b110, 32'h0000_0022, 32'h1234_ABCD, 0, 32'h5555_5555);
        tests++;
        if (obs_done_cyc != 2) begin
            fails++; $display("FAIL sh_latency: got %0d want 2", obs_done_cyc);
        end
        tests++;
        if ({obs_we, obs_addr, obs_be, obs_wdata} !== {1'b1, 32'h20, 4'b1100, 32'hABCD_ABCD}) begin
            fails++; $display("FAIL sh_bus: we %b addr %h be %b wdata %h want 1 00000020 1100 abcdabcd",
                              obs_we, obs_addr, obs_be, obs_wdata);
        end
        tests++;
        if (obs_rd !== 32'h0000_F00D) begin
            fails++; $display("FAIL sh_rd_held: got %h want 0000f00d", obs_rd);
        end
        do_access(3'b011, 32'h0000_0031, 32'hCAFE_BA5E, 0, 32'h0);
        tests++;
        if ({obs_we, obs_addr, obs_be, obs_wdata} !== {1'b1, 32'h30, 4'b0010, 32'h5E5E_5E5E}) begin
            fails++; $display("FAIL sb_bus: we %b addr %h be %b wdata %h want 1 00000030 0010 5e5e5e5e",
                              obs_we, obs_addr, obs_be, obs_wdata);
        end
    endtask

    task automatic test_misalign();
        do_access(3'b010, 32'h0000_0102, 32'h0, 0, 32'h1111_1111);
        tests++;
        if ({obs_done_cyc == 1, obs_misalign, obs_bus_err, obs_req_seen} !== 4'b1100) begin
            fails++; $display("FAIL lw_misalign: cyc %0d mis %b berr %b req %b want 1 1 0 0",
                              obs_done_cyc, obs_misalign, obs_bus_err, obs_req_seen);
        end
        tests++;
        if (obs_rd !== 32'h0000_F00D) begin
            fails++; $display("FAIL misalign_rd_held: got %h want 0000f00d", obs_rd);
        end
        do_access(3'b101, 32'h0000_0101, 32'h0, 0, 32'h1111_1111);
        tests++;
        if ({obs_done_cyc == 1, obs_misalign, obs_req_seen} !== 3'b110) begin
            fails++; $display("FAIL lhu_misalign: cyc %0d mis %b req %b want 1 1 0",
                              obs_done_cyc, obs_misalign, obs_req_seen);
        end
    endtask

    task automatic test_timeout();
        do_access(3'b111, 32'h0000_0040, 32'h0102_0304, 255, 32'h0);
        tests++;
        if ({obs_done_cyc == 5, obs_bus_err, obs_misalign, obs_req_at_done} !== 4'b1100) begin
            fails++; $display("FAIL sw_timeout: cyc %0d berr %b mis %b req %b want 5 1 0 0",
                              obs_done_cyc, obs_bus_err, obs_misalign, obs_req_at_done);
        end
        @(posedge clk); #1;
        tests++;
        if ({bus_if.mem_req, bus_err, done} !== 3'b000) begin
            fails++; $display("FAIL timeout_after: req %b berr %b done %b want 000",
                              bus_if.mem_req, bus_err, done);
        end
        do_access(3'b111, 32'h0000_0040, 32'h0102_0304, 3, 32'h0);
        tests++;
        if ({obs_done_cyc == 5, obs_bus_err, obs_wdata} !== {1'b1, 1'b0, 32'h0102_0304}) begin
            fails++; $display("FAIL ack_last_count: cyc %0d berr %b wdata %h want 5 0 01020304",
                              obs_done_cyc, obs_bus_err, obs_wdata);
        end
    endtask

    task automatic test_back_to_back();
        do_access(3'b010, 32'h0000_0500, 32'h0, 0, 32'hA5A5_0001);
        do_access(3'b010, 32'h0000_0504, 32'h0, 0, 32'hA5A5_0002);
        tests++;
        if ({obs_done_cyc == 2, obs_addr, obs_rd} !== {1'b1, 32'h504, 32'hA5A5_0002}) begin
            fails++; $display("FAIL back_to_back: cyc %0d addr %h rd %h want 2 00000504 a5a50002",
                              obs_done_cyc, obs_addr, obs_rd);
        end
    endtask

    task automatic test_reset_mid_req();
        @(posedge clk); #1;
        start  = 1'b1;
        mem_op = 3'b010;
        Addr   = 32'h0000_0108;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (bus_if.mem_req !== 1'b1) begin
            fails++; $display("FAIL mid_req_pre: req %b want 1", bus_if.mem_req);
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({bus_if.mem_req, stall, done, bus_if.mem_be, bus_if.mem_addr, rd_data} !== 71'h0) begin
            fails++; $display("FAIL mid_req_reset: req %b stall %b done %b be %b addr %h rd %h want all 0",
                              bus_if.mem_req, stall, done, bus_if.mem_be, bus_if.mem_addr, rd_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        do_access(3'b010, 32'h0000_0104, 32'h0, 1, 32'h0BAD_F00D);
        tests++;
        if ({obs_done_cyc == 3, obs_bus_err, obs_rd} !== {1'b1, 1'b0, 32'h0BAD_F00D}) begin
            fails++; $display("FAIL after_reset_lw: cyc %0d berr %b rd %h want 3 0 0badf00d",
                              obs_done_cyc, obs_bus_err, obs_rd);
        end
    endtask

    initial begin
        tests            = 0;
        fails            = 0;
        rst              = 1'b1;
        start            = 1'b0;
        mem_op           = 3'b000;
        Addr             = 32'h0;
        busB             = 32'h0;
        bus_if.mem_rdata = 32'h0;
        bus_if.mem_ack   = 1'b0;
        test_reset();
        test_lw();
        test_byte_loads();
        test_half_loads();
        test_stores();
        test_misalign();
        test_timeout();
        test_back_to_back();
        test_reset_mid_req();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
